rcvr_fifo: RTL
==============

// Module: rcvr_fifo
// PURPOSE
//  Parametrised serial packet receiver with an output FIFO. Hunts SDATA for a HEADER_SIZE-bit
//  header, captures the following BODY_SIZE body bits, splits them into DATA_WIDTH words and
//  buffers them in a FIFO_DEPTH-word FIFO. Words are drained with a READY/ACK handshake.
//  If a packet cannot fit in the FIFO, it is dropped whole and flagged.
// PARAMETERS
//  HEADER_SIZE   8      header length in bits
//  HEADER_VALUE  8'hA5  header pattern, received MSB first
//  BODY_SIZE     16     body bits per packet; must be a multiple of DATA_WIDTH
//  DATA_WIDTH    8      output word width
//  FIFO_DEPTH    4      FIFO words; power of 2, >= WPP
//  WPP (localparam) = BODY_SIZE/DATA_WIDTH, the number of words per packet
// PORTS
//  SCLK      in   1                    clock; all state updates on posedge
//  RST       in   1                    asynchronous, active-low reset
//  SDATA     in   1                    serial data, sampled on posedge SCLK
//  ACK       in   1                    pop request for the head word
//  READY     out  1                    FIFO non-empty; DOUT is valid
//  DOUT      out  DATA_WIDTH           head-of-FIFO word
//  LEVEL     out  clog2(FIFO_DEPTH)+1  FIFO occupancy
//  OVERFLOW  out  1                    one-cycle pulse when a packet is dropped
// BEHAVIOUR
//  Reset (RST=0, async): state=HUNT; shift register, bit counter, pointers and LEVEL cleared.
//   READY=0, DOUT=0, LEVEL=0, OVERFLOW=0. Reset mid-packet discards the partial packet.
//  HUNT: shift SDATA into the HEADER_SIZE-bit register (MSB first).
//   Match test: {sreg[HEADER_SIZE-2:0],SDATA}==HEADER_VALUE, evaluated at the edge sampling the last header bit.
//   Headers may straddle any bit alignment.
//   On match, if free = FIFO_DEPTH-LEVEL >= WPP: go to BODY.
//   On match, if free < WPP: go to DROP and pulse OVERFLOW=1 for exactly one cycle.
//  BODY: bit counter runs 0..BODY_SIZE-1.
//   Bits assemble MSB first into a DATA_WIDTH word register.
//   On each DATA_WIDTH-th bit, the completed word is written to the FIFO at the same edge.
//   After bit BODY_SIZE-1: go to HUNT with the shift register cleared to 0.
//   Body bits are never header candidates: a body of A5 A5 yields two words, not a new header.
//  DROP: same counting as BODY with no FIFO writes; then go to HUNT with the shift register cleared.
//   The space reservation at header time guarantees no write ever hits a full FIFO.
//   ACKs during BODY/DROP only add space.
//  FIFO/handshake:
//   READY = (LEVEL!=0), registered.
//   DOUT = mem[rd_ptr]. A word written at edge N is visible on DOUT/READY after edge N when the FIFO was empty.
//   ACK=1 with READY=1 at a posedge pops one word. ACK with READY=0 is ignored with no underflow.
//   Simultaneous push and pop: LEVEL unchanged, order preserved.
//   Pointers wrap modulo FIFO_DEPTH.
//   Holding ACK high drains one word per cycle.
//   DOUT holds its last value when empty (not cleared, except at reset).
// TESTING
//  T1 reset:
//   Drive random SDATA with RST=0 -> READY=0, DOUT=0, LEVEL=0, OVERFLOW=0.
//   Release -> still idle until a header arrives.
//  T2 single packet:
//   Send A5 3C 5A MSB first.
//   Posedge after the last bit -> READY=1, DOUT=3C, LEVEL=2.
//   ACK -> DOUT=5A; ACK -> READY=0.
//  T3 alignment/near miss:
//   Stream 0xA4 then 0x0_A5_3C_5A_ shifted by 3 bits -> no false detect on A4.
//   Words 3C, 5A received.
//  T4 overflow:
//   Send 3 packets (11 22, 33 44, 55 66) with no ACK, FIFO_DEPTH=4.
//   After the first two packets -> LEVEL=4.
//   Third header -> OVERFLOW one cycle, LEVEL stays 4.
//   Drain -> 11 22 33 44.
//  T5 header-in-body + push/pop collision:
//   Send A5 A5 A5 with ACK asserted on the cycle the second word is written.
//   Words A5, A5 received; LEVEL unchanged that cycle; no extra packet decoded.
//  T6 reset mid-body:
//   Pull RST low after 5 body bits -> LEVEL=0, READY=0.
//   Next packet A5 0F F0 -> words 0F, F0.
//   Also ACK while empty -> no LEVEL change.

Source files
------------

// File: rtl/rcvr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rcvr_fifo
// Brief    : Serial packet receiver with an output word FIFO.
//            Hunts the serial stream for a HEADER_SIZE-bit header (MSB
//            first, any bit alignment), captures the BODY_SIZE body bits
//            that follow, packs them MSB first into DATA_WIDTH words and
//            queues them in a FIFO_DEPTH-word FIFO drained by ready/ack.
//            A packet that cannot fit whole is dropped and flagged.
// Ports    :
//   sclk      in   1           clock, all state updates on rising edge
//   rst       in   1           asynchronous active-low reset
//   sdata     in   1           serial data, sampled on rising sclk
//   ack       in   1           pop request for the head word
//   ready     out  1           FIFO non-empty, dout is valid
//   dout      out  DATA_WIDTH  head-of-FIFO word (holds when empty)
//   level     out  clog2(D)+1  FIFO occupancy
//   overflow  out  1           one-cycle pulse when a packet is dropped
// Revision : 1.0 - initial release
// ============================================================================
module rcvr_fifo #(
  parameter int                     HEADER_SIZE  = 8,
  parameter logic [HEADER_SIZE-1:0] HEADER_VALUE = 8'hA5,
  parameter int                     BODY_SIZE    = 16,
  parameter int                     DATA_WIDTH   = 8,
  parameter int                     FIFO_DEPTH   = 4
) (
  input  logic                          sclk,
  input  logic                          rst,
  input  logic                          sdata,
  input  logic                          ack,
  output logic                          ready,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  // --------------------------------------------------------------------------
  // Derived sizes and constants
  // --------------------------------------------------------------------------
  localparam int WPP = BODY_SIZE / DATA_WIDTH;                  // words per packet
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int BCW = (BODY_SIZE > 1) ? $clog2(BODY_SIZE) : 1;
  localparam int WCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BCW-1:0] C_BODY_LAST = BCW'(BODY_SIZE - 1);
  localparam logic [WCW-1:0] C_WORD_LAST = WCW'(DATA_WIDTH - 1);
  localparam logic [LW-1:0]  C_DEPTH     = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]  C_WPP       = LW'(WPP);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  state_t                  r_state;
  state_t                  w_state_next;

  logic [HEADER_SIZE-1:0]  r_sreg;       // header hunt shift register
  logic [BCW-1:0]          r_bcnt;       // body bit index
  logic [WCW-1:0]          r_wbit;       // bit index within current word
  logic [DATA_WIDTH-1:0]   r_word;       // word under assembly

  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [LW-1:0]           r_level;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic                    r_overflow;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [HEADER_SIZE-1:0]  w_hdr_shift;
  logic                    w_hdr_match;
  logic [DATA_WIDTH-1:0]   w_word_shift;
  logic                    w_word_done;
  logic                    w_body_last;
  logic [LW-1:0]           w_free;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_ovf_set;
  logic [LW-1:0]           w_level_next;
  logic [AW-1:0]           w_rd_next;
  logic [DATA_WIDTH-1:0]   w_head_next;

  // The match is taken on the shifted-in value so the header is recognised
  // at the very edge that samples its last bit.
  assign w_hdr_shift  = HEADER_SIZE'({r_sreg, sdata});
  assign w_hdr_match  = (w_hdr_shift == HEADER_VALUE);
  assign w_word_shift = DATA_WIDTH'({r_word, sdata});
  assign w_word_done  = (r_wbit == C_WORD_LAST);
  assign w_body_last  = (r_bcnt == C_BODY_LAST);

  // Space is reserved for the whole packet when its header arrives, so a
  // body write can never land on a full FIFO; pops during the body only
  // add room.
  assign w_free       = C_DEPTH - r_level;

  assign w_pop        = ack & r_ready;
  assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);
  assign w_rd_next    = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

  // The head after this edge may be the word being written right now
  // (empty FIFO, or the pop exposes the slot currently being filled).
  assign w_head_next  = (w_push && (r_wr_ptr == w_rd_next)) ? w_word_shift
                                                           : r_mem[w_rd_next];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_ovf_set    = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_hdr_match) begin
          if (w_free >= C_WPP) begin
            w_state_next = ST_BODY;
          end else begin
            w_state_next = ST_DROP;
            w_ovf_set    = 1'b1;
          end
        end
      end
      ST_BODY: begin
        w_push = w_word_done;
        if (w_body_last) begin
          w_state_next = ST_HUNT;
        end
      end
      ST_DROP: begin
        if (w_body_last) begin
          w_state_next = ST_HUNT;
        end
      end
      default: begin
        w_state_next = ST_HUNT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Receive datapath: header hunt, body counting, word assembly
  // --------------------------------------------------------------------------
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_sreg     <= '0;
      r_bcnt     <= '0;
      r_wbit     <= '0;
      r_word     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_ovf_set;
      if (r_state == ST_HUNT) begin
        // Cleared on match so the hunt restarts from a clean register
        // after the body; body bits never feed the hunt register.
        r_sreg <= w_hdr_match ? '0 : w_hdr_shift;
        r_bcnt <= '0;
        r_wbit <= '0;
      end else begin
        r_sreg <= '0;
        r_word <= w_word_shift;
        r_bcnt <= w_body_last ? '0 : (r_bcnt + BCW'(1));
        r_wbit <= w_word_done ? '0 : (r_wbit + WCW'(1));
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage, pointers, occupancy and registered head
  // --------------------------------------------------------------------------
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b0;
      r_dout   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word_shift;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_level  <= w_level_next;
      r_ready  <= (w_level_next != '0);
      // Head only refreshes while there is something to show, so the last
      // popped word stays on dout once the FIFO empties.
      if (w_level_next != '0) begin
        r_dout <= w_head_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ready    = r_ready;
  assign dout     = r_dout;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule

`default_nettype wire
